// File: rtl/train_balancer_pkg.sv
// Shared types for the train-balancer models: numeric width and dropoff stop FSM states.
package train_balancer_pkg;

    localparam int unsigned NUM_MSB = 31;

    typedef logic [NUM_MSB:0] num_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UNLOAD = 2'd1,
        ST_DEPART = 2'd2
    } stop_state_t;

endpackage

// File: rtl/dropoff_stop_model_en_route_tracker.sv
// Travel timers for trains assigned to the stop; slot 0 always holds the oldest train.
module en_route_tracker #(
    parameter int unsigned Q      = 3,
    parameter int unsigned TRAVEL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    output logic arrived
);

    localparam int unsigned TW = $clog2(TRAVEL + 1);
    localparam logic [TW-1:0] TRAVEL_T = TW'(TRAVEL);

    logic [Q-1:0]  valid;
    logic [Q-1:0]  valid_next;
    logic [TW-1:0] timer      [Q];
    logic [TW-1:0] timer_next [Q];
    logic          placed;

    // Every train travels the same fixed time, so dispatch order equals arrival
    // order and a shifting queue keeps the oldest arrived train at the head.
    assign arrived = valid[0] && (timer[0] == '0);

    always_comb begin
        valid_next = valid;
        placed     = 1'b0;
        for (int unsigned i = 0; i < Q; i++) begin
            timer_next[i] = (timer[i] != '0) ? timer[i] - 1'b1 : timer[i];
        end
        if (pop) begin
            for (int unsigned i = 0; i + 1 < Q; i++) begin
                valid_next[i] = valid_next[i+1];
                timer_next[i] = timer_next[i+1];
            end
            valid_next[Q-1] = 1'b0;
            timer_next[Q-1] = '0;
        end
        if (push) begin
            for (int unsigned i = 0; i < Q; i++) begin
                if (!placed && !valid_next[i]) begin
                    valid_next[i] = 1'b1;
                    timer_next[i] = TRAVEL_T;
                    placed        = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            for (int unsigned i = 0; i < Q; i++) begin
                timer[i] <= '0;
            end
        end else begin
            valid <= valid_next;
            for (int unsigned i = 0; i < Q; i++) begin
                timer[i] <= timer_next[i];
            end
        end
    end

endmodule

// File: rtl/dropoff_stop_model.sv
// Dropoff train stop: train-limit gated dispatch, unloading into a buffer chest drained by a factory.
// Optional statistics outputs (delivered, starved) are enabled with DROPOFF_STOP_STATS_EN.
module dropoff_stop_model
    import train_balancer_pkg::*;
#(
    parameter int unsigned Q      = 3,
    parameter int unsigned W      = 8000,
    parameter int unsigned B      = 136000,
    parameter int unsigned RATE   = 1000,
    parameter int unsigned TRAVEL = 4,
    parameter int unsigned INT    = NUM_MSB
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [INT:0] l,
    input  logic         dispatch_req,
    output logic         dispatch_ack,
    input  logic [INT:0] drain,
    output logic [INT:0] c,
    output logic [INT:0] t,
    output logic [INT:0] u
`ifdef DROPOFF_STOP_STATS_EN
    ,
    output logic [INT:0] delivered,
    output logic [INT:0] starved
`endif
);

    localparam logic [INT:0] Q_N    = (INT+1)'(Q);
    localparam logic [INT:0] W_N    = (INT+1)'(W);
    localparam logic [INT:0] B_N    = (INT+1)'(B);
    localparam logic [INT:0] RATE_N = (INT+1)'(RATE);
    localparam logic [INT:0] ONE    = (INT+1)'(1);

    stop_state_t  state;
    stop_state_t  state_next;
    logic [INT:0] rem;
    logic [INT:0] rem_next;
    logic [INT:0] c_next;
    logic [INT:0] u_next;
    logic [INT:0] limit;
    logic [INT:0] drain_eff;
    logic [INT:0] room;
    logic [INT:0] x_rate;
    logic [INT:0] x;
    logic [INT+1:0] u_sum;
    logic         arrived;
    logic         take;
    logic         depart;

    en_route_tracker #(
        .Q      (Q),
        .TRAVEL (TRAVEL)
    ) u_tracker (
        .clk     (clk),
        .rst     (rst),
        .push    (dispatch_ack),
        .pop     (take),
        .arrived (arrived)
    );

    assign limit        = (l > Q_N) ? Q_N : l;
    assign dispatch_ack = !rst && dispatch_req && (c < limit);
    assign drain_eff    = (drain > u) ? u : drain;
    // u never exceeds B and drain_eff never exceeds u, so room fits the numeric width.
    assign room         = B_N - u + drain_eff;
    assign x_rate       = (RATE_N < rem) ? RATE_N : rem;
    assign x            = (state != ST_UNLOAD) ? '0 : ((x_rate < room) ? x_rate : room);
    assign u_sum        = {1'b0, u} + {1'b0, x};
    assign u_next       = (INT+1)'(u_sum - {1'b0, drain_eff});
    assign depart       = (state == ST_DEPART);
    assign t            = {{INT{1'b0}}, state != ST_IDLE};

    always_comb begin
        state_next = state;
        take       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arrived) begin
                    state_next = ST_UNLOAD;
                    take       = 1'b1;
                end
            end
            ST_UNLOAD: begin
                if (x == rem) begin
                    state_next = ST_DEPART;
                end
            end
            ST_DEPART: begin
                if (arrived) begin
                    state_next = ST_UNLOAD;
                    take       = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        rem_next = rem;
        if (take) begin
            rem_next = W_N;
        end else if (state == ST_UNLOAD) begin
            rem_next = rem - x;
        end
    end

    always_comb begin
        c_next = c;
        case ({dispatch_ack, depart})
            2'b10:   c_next = c + ONE;
            2'b01:   c_next = c - ONE;
            default: c_next = c;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            rem   <= '0;
            c     <= '0;
            u     <= '0;
        end else begin
            state <= state_next;
            rem   <= rem_next;
            c     <= c_next;
            u     <= u_next;
        end
    end

`ifdef DROPOFF_STOP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            delivered <= '0;
            starved   <= '0;
        end else begin
            if (depart) begin
                delivered <= delivered + ONE;
            end
            if (drain > u) begin
                starved <= starved + ONE;
            end
        end
    end
`endif

endmodule
